voice_allocator: RTL



---
 rtl/synth_pkg.sv | 17 +
 rtl/voice_search.sv | 36 +++
 rtl/voice_allocator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path: note/code widths, voice allocator
// FSM encoding and the tuning lookup's default code.
package synth_pkg;

   localparam int NOTE_W = 7;
   localparam int CODE_W = 32;

   localparam logic [CODE_W-1:0] DEFAULT_CODE = 32'd66213;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOOKUP = 2'd2,
      ST_COMMIT = 2'd3
   } alloc_state_t;

endpackage

// File: rtl/voice_search.sv
// Combinational voice scan: lowest held voice playing note_num (match) and
// lowest voice whose gate is low (free).
module voice_search
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int IDX_W      = $clog2(NUM_VOICES)
) (
   input  logic [NUM_VOICES-1:0]        gate,
   input  logic [NUM_VOICES*NOTE_W-1:0] notes,
   input  logic [NOTE_W-1:0]            note_num,
   output logic                         match_hit,
   output logic [IDX_W-1:0]             match_idx,
   output logic                         free_hit,
   output logic [IDX_W-1:0]             free_idx
);

   // Scanning downwards lets the lowest qualifying voice be the last writer.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (gate[i] && (notes[i*NOTE_W +: NOTE_W] == note_num)) begin
            match_hit = 1'b1;
            match_idx = IDX_W'(i);
         end
         if (!gate[i]) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note events to voice slots and sequences the
// shared tuning lookup. Define VOICE_STEAL_EN to steal voices round-robin when full.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int CODE_W     = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           note_valid,
   output logic                           note_ready,
   input  logic                           note_on,
   input  logic [6:0]                     note_num,
   output logic [6:0]                     lookup_note,
   input  logic [CODE_W-1:0]              lookup_code,
   output logic [NUM_VOICES-1:0]          voice_gate,
   output logic [NUM_VOICES*7-1:0]        voice_note,
   output logic [NUM_VOICES*CODE_W-1:0]   voice_code
);

   localparam int IDX_W = $clog2(NUM_VOICES);

   alloc_state_t             state_q, state_d;
   logic                     ev_on_q, ev_on_d;
   logic [NOTE_W-1:0]        ev_note_q, ev_note_d;
   logic [NOTE_W-1:0]        lookup_note_q, lookup_note_d;
   logic [IDX_W-1:0]         target_q, target_d;
   logic [NUM_VOICES-1:0]    gate_q, gate_d;
   logic [NOTE_W-1:0]        note_q [NUM_VOICES];
   logic [NOTE_W-1:0]        note_d [NUM_VOICES];
   logic [CODE_W-1:0]        code_q [NUM_VOICES];
   logic [CODE_W-1:0]        code_d [NUM_VOICES];
`ifdef VOICE_STEAL_EN
   logic [IDX_W-1:0]         steal_ptr_q, steal_ptr_d;
   logic                     steal_q, steal_d;
`endif

   logic                     match_hit, free_hit;
   logic [IDX_W-1:0]         match_idx, free_idx;

   assign note_ready  = (state_q == ST_IDLE) && !reset;
   assign lookup_note = lookup_note_q;
   assign voice_gate  = gate_q;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
      assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
      assign voice_code[g*CODE_W +: CODE_W] = code_q[g];
   end

   voice_search #(
      .NUM_VOICES (NUM_VOICES)
   ) u_search (
      .gate      (gate_q),
      .notes     (voice_note),
      .note_num  (ev_note_q),
      .match_hit (match_hit),
      .match_idx (match_idx),
      .free_hit  (free_hit),
      .free_idx  (free_idx)
   );

   always_comb begin
      state_d       = state_q;
      ev_on_d       = ev_on_q;
      ev_note_d     = ev_note_q;
      lookup_note_d = lookup_note_q;
      target_d      = target_q;
      gate_d        = gate_q;
      note_d        = note_q;
      code_d        = code_q;
`ifdef VOICE_STEAL_EN
      steal_ptr_d   = steal_ptr_q;
      steal_d       = steal_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (note_valid && note_ready) begin
               ev_on_d   = note_on;
               ev_note_d = note_num;
               state_d   = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            state_d = ST_IDLE;
`ifdef VOICE_STEAL_EN
            steal_d = 1'b0;
`endif
            // Retrigger beats a free slot so a held note never occupies two voices.
            if (ev_on_q && (match_hit || free_hit)) begin
               target_d      = match_hit ? match_idx : free_idx;
               lookup_note_d = ev_note_q;
               state_d       = ST_LOOKUP;
            end
`ifdef VOICE_STEAL_EN
            else if (ev_on_q) begin
               target_d      = steal_ptr_q;
               steal_d       = 1'b1;
               lookup_note_d = ev_note_q;
               state_d       = ST_LOOKUP;
            end
`else
            else if (ev_on_q) begin
               state_d = ST_IDLE;
            end
`endif
            else if (match_hit) begin
               target_d = match_idx;
               state_d  = ST_COMMIT;
            end
         end
         ST_LOOKUP: begin
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            // Note-off only drops the gate; note and code stay for the release tail.
            if (ev_on_q) begin
               gate_d[target_q] = 1'b1;
               note_d[target_q] = ev_note_q;
               code_d[target_q] = lookup_code;
`ifdef VOICE_STEAL_EN
               if (steal_q) begin
                  steal_ptr_d = (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
               end
`endif
            end else begin
               gate_d[target_q] = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ev_on_q       <= 1'b0;
         ev_note_q     <= '0;
         lookup_note_q <= '0;
         target_q      <= '0;
         gate_q        <= '0;
         note_q        <= '{default: '0};
         code_q        <= '{default: '0};
`ifdef VOICE_STEAL_EN
         steal_ptr_q   <= '0;
         steal_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ev_on_q       <= ev_on_d;
         ev_note_q     <= ev_note_d;
         lookup_note_q <= lookup_note_d;
         target_q      <= target_d;
         gate_q        <= gate_d;
         note_q        <= note_d;
         code_q        <= code_d;
`ifdef VOICE_STEAL_EN
         steal_ptr_q   <= steal_ptr_d;
         steal_q       <= steal_d;
`endif
      end
   end

endmodule
